// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter (open-collector pull-low enables)
// Optional NACK detection on the device ack bit: define PS2_TX_ACK_CHK_EN.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_ACK, S_WAIT_IDLE
  } state_t;

  localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [9:0]  shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  clk_sync_q, clk_sync_d;
  logic [1:0]  data_sync_q, data_sync_d;
  logic        clk_oe_q, clk_oe_d;
  logic        data_oe_q, data_oe_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        nack_q, nack_d;
  logic        clk_s, data_s, fall, timed, timeout;

  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk_in};
    data_sync_d = {data_sync_q[0], ps2_data_in};
    clk_s       = clk_sync_q[1];
    data_s      = data_sync_q[1];
    fall        = clk_sync_q[2] & ~clk_sync_q[1];
    timed       = (state_q == S_REQ) || (state_q == S_DATA) ||
                  (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    timeout     = timed && (cnt_q == TIMEOUT_LAST);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = err_q;
    nack_d    = nack_q;

    if (timed) cnt_d = fall ? 20'd0 : cnt_q + 20'd1;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid && ready_q) begin
          state_d  = S_INHIBIT;
          cnt_d    = '0;
          shift_d  = {1'b1, ~^tx_data, tx_data};
          err_d    = 1'b0;
          nack_d   = 1'b0;
          clk_oe_d = 1'b1;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INHIBIT_LAST) begin
          state_d   = S_REQ;
          cnt_d     = '0;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_REQ: begin
        if (fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        // Fall 10 shifts out the stop bit, which releases the data line.
        if (fall) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd8) state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fall) begin
`ifdef PS2_TX_ACK_CHK_EN
          nack_d = data_s;
`else
          nack_d = 1'b0;
`endif
          state_d = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          err_d   = nack_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      err_d     = 1'b1;
      done_d    = 1'b1;
      state_d   = S_IDLE;
    end

    // Ready rises only one cycle after the done pulse, and drops on accept.
    ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      clk_sync_q  <= 3'b111;
      data_sync_q <= 2'b11;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      nack_q      <= nack_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_ready    = ready_q;
  assign busy        = ~ready_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with a PS/2 device model
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INHIB = 20;
  localparam int TMO   = 200;
  localparam int HALF  = 20;
`ifdef PS2_TX_ACK_CHK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, err;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INHIB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic        chk;
    logic        err;
    logic [10:0] frame;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          accepts = 0;
  int          sends = 0;
  logic [10:0] obs_frame = '0;
  bit          frame_active = 0;
  bit          after_done = 0;
  int          viol = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[i + 1] = b[i];
      ones += int'(b[i]);
    end
    f[9]  = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  exp_t e_mon;
  always @(negedge clk) begin
    if (!rst) begin
      frame_active = 0;
      after_done   = 0;
      viol         = 0;
    end else begin
      if (after_done) begin
        check("ready_busy_done_after_done", int'({tx_ready, busy, done}), 4);
        after_done = 0;
      end
      if (frame_active && (tx_ready || !busy)) viol++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e_mon = exp_q.pop_front();
          check("err_at_done", int'(err), int'(e_mon.err));
          if (e_mon.chk) check("frame_bits", int'(obs_frame), int'(e_mon.frame));
        end
        check("busy_window_violations", viol, 0);
        frame_active = 0;
        viol         = 0;
        after_done   = 1;
      end else if (tx_valid && tx_ready) begin
        accepts++;
        frame_active = 1;
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit hold, input bit exp_err,
                      input bit chk, output bit ok);
    int   n;
    exp_t e;
    ok = 0;
    @(posedge clk); #2;
    tx_data  = b;
    tx_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      check("accept_wait", 0, 1);
      @(posedge clk); #2;
      tx_valid = 1'b0;
      return;
    end
    e.frame = model_frame(b);
    e.err   = exp_err;
    e.chk   = chk;
    exp_q.push_back(e);
    sends++;
    @(posedge clk); #2;
    if (!hold) tx_valid = 1'b0;
    tx_data = 8'($urandom);
    @(negedge clk);
    check("clk_oe_after_accept", int'(ps2_clk_oe), 1);
    check("err_cleared_on_accept", int'(err), 0);
    n = 0;
    while (ps2_clk_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_cycles", n, INHIB);
    check("start_bit_data_oe", int'(ps2_data_oe), 1);
    @(posedge clk); #2;
    tx_valid = 1'b0;
    ok = 1;
  endtask

  task automatic device_run(input int stall_at, input int stall_len, input bit nack,
                            input int abort_after);
    logic [10:0] f;
    bit          found;
    int          n;
    f = '0;
    found = 0;
    n = 0;
    while (n < 500 && !found) begin
      @(negedge clk);
      if (ps2_clk_in && !ps2_data_in) found = 1;
      n++;
    end
    if (!found) begin
      check("request_seen", 0, 1);
      return;
    end
    f[0] = ps2_data_in;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      if (i == stall_at) repeat (stall_len) @(negedge clk);
      if (i == 11 && !nack) begin
        dev_data_low = 1'b1;
        repeat (5) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      if (i == abort_after) return;
      if (i <= 10) f[i] = ps2_data_in;
      if (i == 10) obs_frame = f;
      repeat (HALF) @(negedge clk);
    end
  endtask

  initial begin
    bit         ok;
    int         n;
    logic [7:0] b;
    bit         nk;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'({ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, err}), 8);
    @(posedge clk); #2;
    rst = 1'b1;

    send(8'hF4, 0, 0, 1, ok);
    if (ok) device_run(0, 0, 0, 0);

    send(8'hED, 1, 0, 1, ok);
    if (ok) device_run(0, 0, 0, 0);

    send(8'h3C, 0, 1, 0, ok);
    if (ok) begin
      n = 1;
      @(negedge clk);
      while (ps2_data_oe && n < 1000) begin
        n++;
        @(negedge clk);
      end
      check("timeout_cycles", n, TMO);
      check("timeout_release_done", int'({ps2_clk_oe, ps2_data_oe, done}), 1);
    end

    send(8'h55, 0, 0, 1, ok);
    if (ok) begin
      device_run(0, 0, 0, 5);
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midframe_reset_outputs", int'({ps2_clk_oe, ps2_data_oe, tx_ready, done, err}), 4);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      @(posedge clk); #2;
      rst = 1'b1;
    end
    send(8'hFF, 0, 0, 1, ok);
    if (ok) device_run(0, 0, 0, 0);

    send(8'hF5, 0, ACK_CHK, 1, ok);
    if (ok) device_run(0, 0, 1, 0);

    send(8'hA7, 0, 0, 1, ok);
    if (ok) device_run(6, 150, 0, 0);

    for (int k = 0; k < 6; k++) begin
      b  = 8'($urandom);
      nk = 1'($urandom_range(0, 1));
      send(b, 1'($urandom_range(0, 1)), ACK_CHK & nk, 1, ok);
      if (ok) device_run(int'($urandom_range(1, 11)), int'($urandom_range(0, 150)), nk, 0);
    end

    n = 0;
    while ((!tx_ready || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("accept_count", accepts, sends);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
